usb_nrzi_rx: RTL
================

# usb_nrzi_rx

Low-speed USB receive front end: samples the differential line pair once per bit-enable, decodes NRZI, removes stuffed bits, detects SYNC and EOP, and delivers packet bytes LSB-first to the packet layer. It sits between the line pins and the token/descriptor handler, as the receive counterpart of the NRZI/bit-stuff/EOP transmit block. Line state convention is low speed: J = (nrzi=0, nrziNot=1), K = (1,0), SE0 = (0,0).

## Interface
- No parameters.
- useClk  in  1  system clock; all logic on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- checkData  in  1  bit-rate sample enable; the line is sampled only on cycles where it is high.
- nrzi  in  1  D+ level, already synchronised to useClk.
- nrziNot  in  1  D- level, already synchronised to useClk.
- rxActive  out  1  high from SYNC completion until EOP or abort.
- rxData  out  8  last completed byte, LSB = first received bit.
- rxValid  out  1  one-cycle strobe: rxData holds a new byte.
- rxEop  out  1  one-cycle strobe: valid EOP (SE0,SE0,J) closed the packet.
- rxError  out  1  one-cycle strobe: stuff error, byte misalignment at EOP or malformed EOP.

## Operation
- Decode per sample: bit = 1 if line state equals the previous sampled J/K state, 0 if it differs. The previous-state register resets to J and is reloaded to J after every EOP or abort.
- Unstuff: onesCount (3 bits) counts consecutive decoded 1s and clears on any 0. After six 1s, the next bit is a stuff bit. It is discarded and onesCount clears. If that bit is 1, it is a stuff error (see Configuration).
- FSM states: IDLE, SYNC, DATA, EOP1, EOP2, WAIT_J.
- IDLE: wait for the first K. Enter SYNC with shiftReg cleared and the K counted as decoded bit 0.
- SYNC: shift decoded bits. When the 8-bit pattern equals SYNC_PATTERN 8'h80 (KJKJKJKK), set rxActive and go to DATA. Any mismatch returns to WAIT_J. SE0 returns to WAIT_J.
- DATA: shift unstuffed bits into shiftReg LSB-first with a 3-bit bitCount. When the 8th bit lands, rxData takes shiftReg, rxValid pulses and bitCount wraps to 0. On SE0 go to EOP1. A stuff error or a K/J glitch-free abort (both lines high) pulses rxError and goes to WAIT_J.
- EOP1: a second SE0 goes to EOP2. Anything else pulses rxError and goes to WAIT_J.
- EOP2: J pulses rxEop, plus rxError if bitCount != 0, then goes to IDLE. SE0 stays in EOP2 (limit 1 extra sample, then error). K pulses rxError and goes to WAIT_J.
- WAIT_J: clear rxActive and stay until a J sample, then go to IDLE.
- rxActive drops on the cycle rxEop or rxError pulses.

## Timing
- Reset values:
  - rxActive=0, rxData=8'h00, rxValid=0, rxEop=0, rxError=0.
  - state=IDLE, prev line=J, counters 0.
- Strobes assert the useClk cycle after the enabling checkData sample and last exactly one cycle, whatever checkData is doing.
- Byte latency: rxValid is registered one cycle after the checkData cycle that sampled the byte's 8th data bit.
- checkData low: all state holds and no strobe is generated.
- A stuffed bit is never counted in bitCount.
- resetN low mid-packet: immediate return to reset values with no rxError or rxEop.
- Simultaneous events: an 8th bit completing on the same sample as a stuff error still delivers the byte (rxValid) and also pulses rxError.

## Configuration
- USB_RX_STUFF_ERR_EN defined: a 1 in the stuff-bit position aborts the packet with rxError.
- USB_RX_STUFF_ERR_EN undefined: that bit is discarded silently, onesCount restarts at 1, and reception continues.

## Structure
- Package usb_rx_pkg holds:
  - line-state typedef (J, K, SE0, SE1)
  - FSM state typedef
  - SYNC_PATTERN = 8'h80
  - STUFF_LIMIT = 6
- Sub-module usb_line_decoder handles line-state classification, NRZI decode and unstuffing. It outputs bitValid, bitVal, lineState and stuffErr. The top contains the FSM and byte assembly.

## Test plan
- Idle J, then SYNC KJKJKJKK, then NRZI byte 8'hC3, then SE0,SE0,J -> rxActive high after SYNC; rxValid once with rxData=8'hC3; rxEop one cycle; rxError never.
- Byte 8'hFF followed by 8'h01 -> stuff bit after the 6th one is removed; rxData sequence FF, 01.
- Seven consecutive 1s in DATA, macro defined -> rxError pulse, rxActive=0, WAIT_J until J. Macro undefined -> no error, reception continues.
- EOP after 12 data bits -> rxValid once (first byte), then rxEop and rxError together.
- SYNC with 5th symbol corrupted (KJKJJ...) -> no rxActive, back to IDLE after J, next clean packet received.
- resetN pulsed low mid-byte with checkData toggling -> all outputs 0 immediately; next packet decodes correctly.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the low-speed USB receive front end.
package usb_rx_pkg;

  // Encoded as {D+, D-}: J = 01, K = 10 (low-speed convention).
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP1,
    ST_EOP2,
    ST_WAIT_J
  } rx_state_t;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;

  function automatic line_state_t classify(input logic dp, input logic dm);
    return line_state_t'({dp, dm});
  endfunction

endpackage

// File: rtl/usb_line_decoder.sv
// Line-state classification, NRZI decode and bit unstuffing.
// USB_RX_STUFF_ERR_EN: a 1 in the stuff position is flagged instead of silently dropped.
module usb_line_decoder
  import usb_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_sample,
  input  logic        i_dp,
  input  logic        i_dm,
  input  logic        i_unstuff_en,
  input  logic        i_clear,
  output logic        o_bit_valid,
  output logic        o_bit_val,
  output line_state_t o_line_state,
  output logic        o_stuff_err
);

  line_state_t r_prev;
  logic [2:0]  r_ones;
  logic        w_jk;
  logic        w_dec;
  logic        w_stuff_slot;

  assign o_line_state = classify(i_dp, i_dm);

  always_comb begin
    w_jk         = (o_line_state == LS_J) || (o_line_state == LS_K);
    w_dec        = (o_line_state == r_prev);
    w_stuff_slot = i_unstuff_en && (r_ones == STUFF_LIMIT);
    o_bit_val    = w_dec;
    o_bit_valid  = i_sample && w_jk && !w_stuff_slot;
`ifdef USB_RX_STUFF_ERR_EN
    o_stuff_err  = i_sample && w_jk && w_stuff_slot && w_dec;
`else
    o_stuff_err  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= LS_J;
      r_ones <= '0;
    end else if (i_clear) begin
      r_prev <= LS_J;
      r_ones <= '0;
    end else if (i_sample && w_jk) begin
      r_prev <= o_line_state;
      if (!i_unstuff_en) begin
        r_ones <= '0;
      end else if (w_stuff_slot) begin
`ifdef USB_RX_STUFF_ERR_EN
        r_ones <= '0;
`else
        // A 1 in the stuff slot is dropped but still starts a new run of ones.
        r_ones <= w_dec ? 3'd1 : 3'd0;
`endif
      end else begin
        r_ones <= w_dec ? r_ones + 3'd1 : 3'd0;
      end
    end
  end

endmodule

// File: rtl/usb_nrzi_rx.sv
// Low-speed USB receive front end: SYNC/EOP framing FSM and LSB-first byte assembly.
// USB_RX_STUFF_ERR_EN selects abort-on-stuff-error inside usb_line_decoder.
module usb_nrzi_rx
  import usb_rx_pkg::*;
(
  input  logic       useClk,
  input  logic       resetN,
  input  logic       checkData,
  input  logic       nrzi,
  input  logic       nrziNot,
  output logic       rxActive,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       rxEop,
  output logic       rxError
);

  rx_state_t   r_state, w_state_n;
  logic [7:0]  r_shift, w_shift_n;
  logic [7:0]  r_data, w_data_n;
  logic [2:0]  r_cnt, w_cnt_n;
  logic        r_active, w_active_n;
  logic        r_valid, w_valid_n;
  logic        r_eop, w_eop_n;
  logic        r_err, w_err_n;
  logic        r_eop_ext, w_eop_ext_n;
  logic        w_clear;
  logic        w_unstuff_en;
  logic        w_bit_valid;
  logic        w_bit_val;
  logic        w_stuff_err;
  logic [7:0]  w_shifted;
  line_state_t w_line;

  assign w_unstuff_en = (r_state == ST_SYNC) || (r_state == ST_DATA);
  assign w_shifted    = {w_bit_val, r_shift[7:1]};

  usb_line_decoder u_dec (
    .clk          (useClk),
    .rst_n        (resetN),
    .i_sample     (checkData),
    .i_dp         (nrzi),
    .i_dm         (nrziNot),
    .i_unstuff_en (w_unstuff_en),
    .i_clear      (w_clear),
    .o_bit_valid  (w_bit_valid),
    .o_bit_val    (w_bit_val),
    .o_line_state (w_line),
    .o_stuff_err  (w_stuff_err)
  );

  always_comb begin
    w_state_n   = r_state;
    w_shift_n   = r_shift;
    w_data_n    = r_data;
    w_cnt_n     = r_cnt;
    w_active_n  = r_active;
    w_eop_ext_n = r_eop_ext;
    w_valid_n   = 1'b0;
    w_eop_n     = 1'b0;
    w_err_n     = 1'b0;
    w_clear     = 1'b0;
    if (checkData) begin
      case (r_state)
        ST_IDLE: begin
          if (w_line == LS_K) begin
            w_state_n = ST_SYNC;
            w_shift_n = '0;
            w_cnt_n   = 3'd1;
          end
        end
        ST_SYNC: begin
          if ((w_line == LS_SE0) || (w_line == LS_SE1)) begin
            w_state_n = ST_WAIT_J;
            w_clear   = 1'b1;
          end else if (w_bit_valid) begin
            // Checked bit by bit so a corrupted SYNC is dropped as soon as it diverges.
            w_shift_n = w_shifted;
            if (w_bit_val != SYNC_PATTERN[r_cnt]) begin
              w_state_n = ST_WAIT_J;
              w_clear   = 1'b1;
            end else begin
              w_cnt_n = r_cnt + 3'd1;
              if (r_cnt == 3'd7) begin
                w_state_n  = ST_DATA;
                w_active_n = 1'b1;
              end
            end
          end
        end
        ST_DATA: begin
          if (w_bit_valid) begin
            w_shift_n = w_shifted;
            w_cnt_n   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_data_n  = w_shifted;
              w_valid_n = 1'b1;
            end
          end
          if (w_line == LS_SE0) begin
            w_state_n = ST_EOP1;
          end else if ((w_line == LS_SE1) || w_stuff_err) begin
            w_err_n    = 1'b1;
            w_active_n = 1'b0;
            w_state_n  = ST_WAIT_J;
            w_clear    = 1'b1;
          end
        end
        ST_EOP1: begin
          if (w_line == LS_SE0) begin
            w_state_n   = ST_EOP2;
            w_eop_ext_n = 1'b0;
          end else begin
            w_err_n    = 1'b1;
            w_active_n = 1'b0;
            w_state_n  = ST_WAIT_J;
            w_clear    = 1'b1;
          end
        end
        ST_EOP2: begin
          if (w_line == LS_J) begin
            w_eop_n    = 1'b1;
            w_err_n    = (r_cnt != 3'd0);
            w_active_n = 1'b0;
            w_state_n  = ST_IDLE;
            w_clear    = 1'b1;
          end else if ((w_line == LS_SE0) && !r_eop_ext) begin
            w_eop_ext_n = 1'b1;
          end else begin
            w_err_n    = 1'b1;
            w_active_n = 1'b0;
            w_state_n  = ST_WAIT_J;
            w_clear    = 1'b1;
          end
        end
        ST_WAIT_J: begin
          w_active_n = 1'b0;
          if (w_line == LS_J) w_state_n = ST_IDLE;
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge useClk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_data    <= '0;
      r_cnt     <= '0;
      r_active  <= 1'b0;
      r_valid   <= 1'b0;
      r_eop     <= 1'b0;
      r_err     <= 1'b0;
      r_eop_ext <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_shift   <= w_shift_n;
      r_data    <= w_data_n;
      r_cnt     <= w_cnt_n;
      r_active  <= w_active_n;
      r_valid   <= w_valid_n;
      r_eop     <= w_eop_n;
      r_err     <= w_err_n;
      r_eop_ext <= w_eop_ext_n;
    end
  end

  assign rxActive = r_active;
  assign rxData   = r_data;
  assign rxValid  = r_valid;
  assign rxEop    = r_eop;
  assign rxError  = r_err;

endmodule
